// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants used by the writeback / register-file slice.
package pipeline_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;

endpackage

// File: rtl/wb_select.sv
// WB-stage data select: load data when MemToReg is set, ALU result otherwise.
module wb_select #(
   parameter int WIDTH = 32
) (
   input  logic             mem_to_reg,
   input  logic [WIDTH-1:0] mem_data,
   input  logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] wb_data
);

   assign wb_data = mem_to_reg ? mem_data : alu_result;

endmodule

// File: rtl/writeback_regfile.sv
// MEM/WB consumer: selects WB data, commits it to the GPR file and serves two bypassed
// ID read ports, an unbypassed debug read port and a retired-write counter.
module writeback_regfile
   import pipeline_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] alu_result_in,
   input  logic [ADDR_WIDTH-1:0] reg_dest_in,
   input  logic                  MemToReg_in,
   input  logic                  RegWrite_in,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   output logic [DATA_WIDTH-1:0] wb_data_out,
   output logic                  wb_valid_out,
   input  logic [ADDR_WIDTH-1:0] debug_addr,
   output logic [DATA_WIDTH-1:0] debug_data,
   output logic [CNT_WIDTH-1:0]  wb_count
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // r0 reads as zero; a same-cycle write to the requested index is forwarded.
   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [ADDR_WIDTH-1:0] idx,
      input logic                  valid,
      input logic [ADDR_WIDTH-1:0] dest,
      input logic [DATA_WIDTH-1:0] bypass,
      input logic [DATA_WIDTH-1:0] stored
   );
      if (idx == ZERO_IDX) return '0;
      if (valid && (idx == dest)) return bypass;
      return stored;
   endfunction

   wb_select #(
      .WIDTH(DATA_WIDTH)
   ) u_wb_select (
      .mem_to_reg(MemToReg_in),
      .mem_data  (mem_data_in),
      .alu_result(alu_result_in),
      .wb_data   (wb_data_out)
   );

   assign wb_valid_out = RegWrite_in && (reg_dest_in != ZERO_IDX);

   assign read_data1 = read_port(read_reg1, wb_valid_out, reg_dest_in, wb_data_out,
                                 regs[read_reg1]);
   assign read_data2 = read_port(read_reg2, wb_valid_out, reg_dest_in, wb_data_out,
                                 regs[read_reg2]);
   assign debug_data = (debug_addr == ZERO_IDX) ? '0 : regs[debug_addr];

   // Reset wins over a coincident commit: the write is dropped and not counted.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         wb_count <= '0;
      end else if (wb_valid_out) begin
         regs[reg_dest_in] <= wb_data_out;
         wb_count          <= wb_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios then randomized traffic against an array model.
module tb_writeback_regfile;

   localparam int CW = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] mem_data_in, alu_result_in;
   logic [4:0]  reg_dest_in;
   logic        MemToReg_in, RegWrite_in;
   logic [4:0]  read_reg1, read_reg2, debug_addr;
   logic [31:0] read_data1, read_data2, wb_data_out, debug_data;
   logic        wb_valid_out;
   logic [CW-1:0] wb_count;

   int tests = 0;
   int fails = 0;

   logic [31:0] mregs [32];
   int          mcnt;

   always #5 clock = ~clock;

   writeback_regfile #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5),
      .CNT_WIDTH (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .mem_data_in  (mem_data_in),
      .alu_result_in(alu_result_in),
      .reg_dest_in  (reg_dest_in),
      .MemToReg_in  (MemToReg_in),
      .RegWrite_in  (RegWrite_in),
      .read_reg1    (read_reg1),
      .read_reg2    (read_reg2),
      .read_data1   (read_data1),
      .read_data2   (read_data2),
      .wb_data_out  (wb_data_out),
      .wb_valid_out (wb_valid_out),
      .debug_addr   (debug_addr),
      .debug_data   (debug_data),
      .wb_count     (wb_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_wb();
      return MemToReg_in ? mem_data_in : alu_result_in;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (RegWrite_in && reg_dest_in != 5'd0 && idx == reg_dest_in) return model_wb();
      return mregs[idx];
   endfunction

   // Advance one clock, updating the model from the inputs held at the edge.
   task automatic step();
      @(posedge clock);
      if (reset) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
         mcnt = 0;
      end else if (RegWrite_in && reg_dest_in != 5'd0) begin
         mregs[reg_dest_in] = model_wb();
         mcnt = (mcnt + 1) % (1 << CW);
      end
      #1;
   endtask

   task automatic drive(input logic we, input logic m2r, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [31:0] mem);
      RegWrite_in   = we;
      MemToReg_in   = m2r;
      reg_dest_in   = dest;
      alu_result_in = alu;
      mem_data_in   = mem;
      #1;
   endtask

   task automatic check_all(input string tag, input logic chk_wb);
      check({tag, ".rd1"}, read_data1, model_read(read_reg1));
      check({tag, ".rd2"}, read_data2, model_read(read_reg2));
      if (chk_wb) check({tag, ".wb"}, wb_data_out, model_wb());
      check({tag, ".valid"}, {31'd0, wb_valid_out},
            {31'd0, (RegWrite_in === 1'b1) && reg_dest_in != 5'd0});
      check({tag, ".dbg"}, debug_data, (debug_addr == 5'd0) ? 32'd0 : mregs[debug_addr]);
      check({tag, ".cnt"}, {28'd0, wb_count}, 32'(mcnt));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt = 0;
      reset = 1'b1;
      read_reg1 = 5'd0; read_reg2 = 5'd0; debug_addr = 5'd0;
      drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

      // 1: reset, then every index reads zero
      step(); step();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         debug_addr = 5'(i);
         #1;
         check($sformatf("reset.dbg%0d", i), debug_data, 32'd0);
      end
      check("reset.cnt", {28'd0, wb_count}, 32'd0);

      // 2: ALU write to r5, bypassed same cycle, stored next cycle
      read_reg1 = 5'd5; debug_addr = 5'd5;
      drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
      check("t2.bypass", read_data1, 32'hDEADBEEF);
      check("t2.dbg_pre", debug_data, 32'd0);
      step();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      check("t2.dbg", debug_data, 32'hDEADBEEF);
      check("t2.rd1", read_data1, 32'hDEADBEEF);
      check("t2.cnt", {28'd0, wb_count}, 32'd1);

      // 3: write to r0 is dropped
      read_reg1 = 5'd0; debug_addr = 5'd0;
      drive(1'b1, 1'b0, 5'd0, 32'h1234, 32'h0);
      check("t3.rd1", read_data1, 32'd0);
      check("t3.valid", {31'd0, wb_valid_out}, 32'd0);
      step();
      check("t3.dbg", debug_data, 32'd0);
      check("t3.cnt", {28'd0, wb_count}, 32'd1);

      // 4: load data to r7 seen on both ports
      read_reg1 = 5'd7; read_reg2 = 5'd7;
      drive(1'b1, 1'b1, 5'd7, 32'h1, 32'hCAFEF00D);
      check("t4.rd1", read_data1, 32'hCAFEF00D);
      check("t4.rd2", read_data2, 32'hCAFEF00D);
      check("t4.wb", wb_data_out, 32'hCAFEF00D);
      step();

      // 5: reset beats a coincident write; r9 first holds a value
      debug_addr = 5'd9;
      drive(1'b1, 1'b0, 5'd9, 32'h77, 32'h0);
      step();
      check("t5.pre", debug_data, 32'h77);
      reset = 1'b1;
      read_reg1 = 5'd9;
      drive(1'b1, 1'b0, 5'd9, 32'h55, 32'h0);
      check("t5.bypass_in_reset", read_data1, 32'h55);
      step();
      reset = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      check("t5.dbg", debug_data, 32'd0);
      check("t5.cnt", {28'd0, wb_count}, 32'd0);

      // X on MemToReg with RegWrite low leaves storage alone
      debug_addr = 5'd7;
      drive(1'b0, 1'bx, 5'd7, 32'hAAAA, 32'hBBBB);
      step();
      check("tx.dbg", debug_data, 32'd0);
      check("tx.cnt", {28'd0, wb_count}, 32'd0);

      // 6: counter wraps after 16 commits
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 1'b0, 5'(1 + i), 32'(i), 32'h0);
         step();
      end
      check("t6.cnt15", {28'd0, wb_count}, 32'd15);
      drive(1'b1, 1'b0, 5'd20, 32'h99, 32'h0);
      step();
      check("t6.wrap", {28'd0, wb_count}, 32'd0);

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic we, m2r;
         reset      = ($urandom_range(0, 31) == 0);
         read_reg1  = 5'($urandom_range(0, 31));
         read_reg2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : read_reg1;
         debug_addr = 5'($urandom_range(0, 31));
         we  = ($urandom_range(0, 3) != 0);
         m2r = 1'($urandom_range(0, 1));
         drive(we, m2r, ($urandom_range(0, 1) == 0) ? read_reg1 : 5'($urandom_range(0, 31)),
               $urandom, $urandom);
         check_all($sformatf("rnd%0d", n), 1'b1);
         step();
         check_all($sformatf("rnd%0d.post", n), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
